// File: rtl/mux3_rr_arb_pkg.sv
// Shared types, select encodings and arbitration helpers for the
// three-way round-robin arbiter with output multiplexer.
package mux3_rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Select codes driven onto {s1, s0}; 2'b11 is never produced.
    localparam logic [1:0] SEL_X1 = 2'b00;
    localparam logic [1:0] SEL_X2 = 2'b01;
    localparam logic [1:0] SEL_X3 = 2'b10;

    // Width of the per-grant transfer counter (enough for HOLD up to 15).
    localparam int CNT_W = 4;

    // Select code for granted index g (0..2).
    function automatic logic [1:0] sel_of(input logic [1:0] g);
        logic [1:0] sel;
        case (g)
            2'd1:    sel = SEL_X2;
            2'd2:    sel = SEL_X3;
            default: sel = SEL_X1;
        endcase
        return sel;
    endfunction

    // Successor of index g modulo 3.
    function automatic logic [1:0] next_idx(input logic [1:0] g);
        return (g == 2'd2) ? 2'd0 : g + 2'd1;
    endfunction

    // First requester with req set, searching ptr, ptr+1, ptr+2 (mod 3).
    // Scans in reverse so the earliest hit in search order wins.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [1:0] pick;
        logic [2:0] idx;
        pick = ptr;
        for (int k = 2; k >= 0; k--) begin
            idx = 3'(ptr) + 3'(k);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (req[idx[1:0]]) pick = idx[1:0];
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux3_sel.sv
// Combinational 3:1 data selector driven by a two-bit select encoding.
module mux3_sel #(
    parameter int W = 8
) (
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] x3,
    input  logic         s0,
    input  logic         s1,
    output logic [W-1:0] f
);

    // s1 has priority and selects x3; otherwise s0 picks x2 over x1.
    always_comb begin
        if (s1)      f = x3;
        else if (s0) f = x2;
        else         f = x1;
    end

endmodule

// File: rtl/mux3_rr_arb.sv
// Three-requester round-robin arbiter. A grant is held until the
// owner drops its request or HOLD transfers complete; every release
// costs one IDLE cycle and advances the round-robin pointer.
module mux3_rr_arb
    import mux3_rr_arb_pkg::*;
#(
    parameter int W    = 8,
    parameter int HOLD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   req,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] x3,
    input  logic         out_ready,
    output logic [2:0]   gnt,
    output logic         s0,
    output logic         s1,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         busy
);

    state_e           state_q, state_d;
    logic [1:0]       ptr_q,   ptr_d;
    logic [1:0]       g_q,     g_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       gnt_q,   gnt_d;
    logic [1:0]       sel_q,   sel_d;

    logic req_g;
    logic xfer;
    logic hold_hit;

    // gnt_q is zero in IDLE, so this is req[g] while granted and 0 otherwise.
    assign req_g    = |(req & gnt_q);
    assign xfer     = out_valid & out_ready;
    assign hold_hit = (cnt_q == CNT_W'(HOLD - 1));

    // State register.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Grant bookkeeping registers: pointer, owner, transfer count, grant and select.
    // NOTE: the asynchronous reset clears every control flop, so an
    // interrupted grant is abandoned and never resumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
            g_q   <= 2'd0;
            cnt_q <= '0;
            gnt_q <= 3'b000;
            sel_q <= SEL_X1;
        end else begin
            ptr_q <= ptr_d;
            g_q   <= g_d;
            cnt_q <= cnt_d;
            gnt_q <= gnt_d;
            sel_q <= sel_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, count transfers and release in GRANT.
    // NOTE: every target gets a default before the case so no path
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (req != 3'b000) begin
                    g_d     = rr_pick(req, ptr_q);
                    gnt_d   = 3'b001 << g_d;
                    sel_d   = sel_of(g_d);
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Request drop and HOLD limit share one release path, so a
                // coincidence of both still advances the pointer only once.
                if (!req_g || (xfer && hold_hit)) begin
                    ptr_d   = next_idx(g_q);
                    gnt_d   = 3'b000;
                    sel_d   = SEL_X1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        busy      = (state_q == GRANT);
        out_valid = busy & req_g;
        gnt       = gnt_q;
        s1        = sel_q[1];
        s0        = sel_q[0];
    end

    mux3_sel #(
        .W(W)
    ) u_mux3_sel (
        .x1(x1),
        .x2(x2),
        .x3(x3),
        .s0(s0),
        .s1(s1),
        .f (out_data)
    );

endmodule

// File: tb/tb_mux3_rr_arb.sv
// Self-checking bench for mux3_rr_arb: a reset-to-release vector table,
// directed corner sequences, and a randomized run against a behavioural
// model that tracks only "who owns the grant, how many transfers, where
// the pointer is".
module tb_mux3_rr_arb;

    localparam int W    = 8;
    localparam int HOLD = 4;

    logic         clk;
    logic         rst_n;
    logic [2:0]   req;
    logic [W-1:0] x1, x2, x3;
    logic         out_ready;
    logic [2:0]   gnt;
    logic         s0, s1;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         busy;

    mux3_rr_arb #(
        .W   (W),
        .HOLD(HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .x1       (x1),
        .x2       (x2),
        .x3       (x3),
        .out_ready(out_ready),
        .gnt      (gnt),
        .s0       (s0),
        .s1       (s1),
        .out_valid(out_valid),
        .out_data (out_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: m_g = owner index or -1 when idle.
    int m_g   = -1;
    int m_ptr = 0;
    int m_cnt = 0;

    typedef struct {
        logic [2:0] req;
        logic       rdy;
        logic [2:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       busy;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_g   = -1;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    // Compare all outputs against what the model says for the current inputs.
    task automatic check_model();
        logic [2:0]   eg;
        logic [1:0]   es;
        logic         ev;
        logic [W-1:0] ed;
        if (m_g < 0) begin
            eg = 3'b000; es = 2'b00; ev = 1'b0; ed = x1;
        end else begin
            eg = 3'(1 << m_g);
            es = 2'(m_g);
            ev = req[m_g];
            ed = (m_g == 0) ? x1 : (m_g == 1) ? x2 : x3;
        end
        check("model_gnt",   32'(gnt),         32'(eg));
        check("model_sel",   32'({s1, s0}),    32'(es));
        check("model_valid", 32'(out_valid),   32'(ev));
        check("model_busy",  32'(busy),        32'(m_g >= 0));
        check("model_data",  32'(out_data),    32'(ed));
    endtask

    // Advance the model by one clock edge using the inputs the DUT samples.
    task automatic model_step();
        bit found;
        bit xfer;
        int idx;
        if (m_g < 0) begin
            found = 0;
            for (int k = 0; k < 3; k++) begin
                idx = (m_ptr + k) % 3;
                if (!found && req[idx]) begin
                    found = 1;
                    m_g   = idx;
                end
            end
            m_cnt = 0;
        end else begin
            xfer = req[m_g] && out_ready;
            if (!req[m_g] || (xfer && m_cnt == HOLD - 1)) begin
                m_ptr = (m_g + 1) % 3;
                m_g   = -1;
                m_cnt = 0;
            end else if (xfer) begin
                m_cnt++;
            end
        end
    endtask

    // Apply inputs just after a falling edge, then check away from the rising edge.
    task automatic drive(input logic [2:0] r, input logic rdy);
        req       = r;
        out_ready = rdy;
        #1;
        check_model();
    endtask

    task automatic advance();
        model_step();
        @(negedge clk);
    endtask

    // Assert reset at a falling edge and check outputs clear before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_gnt",   32'(gnt),       32'h0);
        check("rst_sel",   32'({s1, s0}),  32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] data_of(input logic [1:0] sel);
        return (sel == 2'b10) ? x3 : (sel == 2'b01) ? x2 : x1;
    endfunction

    initial begin
        int xfers;
        int run_xfers;
        logic [2:0] exp_gnt;

        rst_n     = 1'b0;
        req       = 3'b000;
        out_ready = 1'b0;
        x1        = 8'h11;
        x2        = 8'hA5;
        x3        = 8'h3C;

        // req=010 held: grant after one cycle, four transfers, release, then
        // req=111 in the bubble must go to requester 3 because ptr is 2.
        vecs[0] = '{3'b010, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0};
        vecs[1] = '{3'b010, 1'b1, 3'b010, 2'b01, 1'b1, 1'b1};
        vecs[2] = '{3'b010, 1'b1, 3'b010, 2'b01, 1'b1, 1'b1};
        vecs[3] = '{3'b010, 1'b1, 3'b010, 2'b01, 1'b1, 1'b1};
        vecs[4] = '{3'b010, 1'b1, 3'b010, 2'b01, 1'b1, 1'b1};
        vecs[5] = '{3'b111, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0};
        vecs[6] = '{3'b111, 1'b1, 3'b100, 2'b10, 1'b1, 1'b1};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].req, vecs[i].rdy);
            check($sformatf("vec%0d_gnt", i),   32'(gnt),       32'(vecs[i].gnt));
            check($sformatf("vec%0d_sel", i),   32'({s1, s0}),  32'(vecs[i].sel));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_busy", i),  32'(busy),      32'(vecs[i].busy));
            check($sformatf("vec%0d_data", i),  32'(out_data),  32'(data_of(vecs[i].sel)));
            advance();
        end

        // All three requesting: 001,010,100,001 for HOLD cycles each, one bubble between.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            drive(3'b111, 1'b1);
            exp_gnt = (c % 5 == 0) ? 3'b000 : 3'(1 << ((c / 5) % 3));
            check("rr_seq_gnt", 32'(gnt), 32'(exp_gnt));
            advance();
        end

        // Stall on requester 1: counter must not move while out_ready is low.
        do_reset();
        drive(3'b001, 1'b0);
        advance();
        for (int c = 0; c < 10; c++) begin
            drive(3'b001, 1'b0);
            check("stall_gnt",   32'(gnt),       32'h1);
            check("stall_valid", 32'(out_valid), 32'h1);
            advance();
        end
        xfers = 0;
        for (int c = 0; c < 8 && (c == 0 || busy); c++) begin
            drive(3'b001, 1'b1);
            if (out_valid && out_ready) xfers++;
            advance();
        end
        check("stall_xfers", 32'(xfers), 32'(HOLD));
        drive(3'b001, 1'b1);
        check("stall_release_busy", 32'(busy), 32'h0);
        advance();

        // Requester 3 drops after two transfers: immediate release, ptr wraps to 0.
        do_reset();
        drive(3'b100, 1'b1); advance();
        drive(3'b100, 1'b1); advance();
        drive(3'b100, 1'b1); advance();
        drive(3'b000, 1'b1);
        check("drop_valid", 32'(out_valid), 32'h0);
        check("drop_busy",  32'(busy),      32'h1);
        advance();
        drive(3'b111, 1'b1);
        check("drop_idle_busy", 32'(busy), 32'h0);
        advance();
        drive(3'b111, 1'b1);
        check("drop_wrap_gnt", 32'(gnt), 32'h1);
        advance();

        // Reset mid-grant with cnt=2, then req=100 is granted from scratch.
        do_reset();
        drive(3'b100, 1'b1); advance();
        drive(3'b100, 1'b1); advance();
        drive(3'b100, 1'b1); advance();
        do_reset();
        drive(3'b100, 1'b1);
        check("post_rst_idle", 32'(busy), 32'h0);
        advance();
        drive(3'b100, 1'b1);
        check("post_rst_gnt", 32'(gnt), 32'h4);
        advance();

        // Randomized traffic against the model plus structural invariants.
        do_reset();
        run_xfers = 0;
        for (int c = 0; c < 10000; c++) begin
            x1 = W'($urandom);
            x2 = W'($urandom);
            x3 = W'($urandom);
            drive(3'($urandom), ($urandom_range(0, 3) != 0));
            check("rand_onehot0", 32'($onehot0(gnt)), 32'h1);
            check("rand_sel_legal", 32'({s1, s0} != 2'b11), 32'h1);
            if (!busy) run_xfers = 0;
            if (out_valid && out_ready) begin
                run_xfers++;
                check("rand_hold_limit", 32'(run_xfers <= HOLD), 32'h1);
            end
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
